// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, data width, baud divisor calculation.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Rounded clock-to-baud ratio.
    function automatic int unsigned calc_div(input int unsigned clk, input int unsigned baud);
        return (clk + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with exact registered occupancy; head entry visible on rd_data_o.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == (AW + 1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so a push into a full FIFO succeeds alongside it.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CntW = $clog2(DIV);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_fifo: baud divisor must be at least 4");
    end

    localparam logic [CntW-1:0] HalfLoad = CntW'(DIV / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(DIV - 1);

    logic                 rx_meta_q, rx_s_q;
    uart_rx_state_t       state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 framing_q, framing_d;
    logic                 overrun_q, overrun_d;
    logic                 push, cnt_zero;
    logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_q, parity_d;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        framing_d = 1'b0;
        push      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        parity_d  = 1'b0;
`endif
        unique case (state_q)
            WAIT_IDLE: if (rx_s_q) state_d = IDLE;
            IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HalfLoad;
                    state_d = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (!rx_s_q) begin
                    cnt_d   = FullLoad;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;  // start bit did not hold to mid-bit
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    data_d[idx_q] = rx_s_q;
                    cnt_d         = FullLoad;
                    idx_d         = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    par_bad_d = ^{data_q, rx_s_q};
                    cnt_d     = FullLoad;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_s_q) begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (par_bad_q) parity_d = 1'b1;
                    else           push     = 1'b1;
`else
                    push = 1'b1;
`endif
                end else begin
                    framing_d = 1'b1;
                    state_d   = WAIT_IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign overrun_d = push && fifo_full && !(out_ready && !fifo_empty);

    always_ff @(posedge clk50) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= WAIT_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            framing_q <= framing_d;
            overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            parity_q  <= parity_d;
`endif
        end
    end

    assign framing_err = framing_q;
    assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_q;
`else
    assign parity_err  = 1'b0;
`endif

    assign out_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk50),
        .rst_i     (reset),
        .wr_en_i   (push),
        .wr_data_i (data_q),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo at DIV=10, scoreboarded against a byte-queue model.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 5000000;
    localparam int DEPTH    = 16;
    localparam int DIV      = 10;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Cycles from driving the start edge to out_valid: 2 sync flops, 1 detect, half bit, rest of frame.
    localparam int LAT = 3 + DIV / 2 + (FRAME_BITS - 1) * DIV;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [4:0] fifo_count;
    logic       framing_err, overrun, parity_err;

    always #10 clk50 = ~clk50;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50       (clk50),
        .reset       (reset),
        .rx          (rx),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .framing_err (framing_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, bad_pulse = 0;
    logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;
    bit rand_ready = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: monitor at the falling edge, then advance inputs just after the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk50);
        if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("pop_data", int'(out_data), int'(e));
            end else begin
                check_eq("pop_with_empty_model", int'(out_valid), 0);
            end
        end
        fe_cnt += int'(framing_err);
        ov_cnt += int'(overrun);
        pe_cnt += int'(parity_err);
        if (int'(framing_err) + int'(overrun) + int'(parity_err) > 1) bad_pulse++;
        if ((framing_err && prev_fe) || (overrun && prev_ov) || (parity_err && prev_pe)) bad_pulse++;
        if (out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = out_valid;
        prev_fe    = framing_err;
        prev_ov    = overrun;
        prev_pe    = parity_err;
        @(posedge clk50);
        #1;
        cyc++;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        logic [10:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par_bit;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
        bits[10] = par_bit;
`endif
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx = bits[i];
            repeat (DIV) tick();
        end
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    int start, fe0, ov0, pe0;
    logic [7:0] rb;

    initial begin
        repeat (4) tick();
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_fifo_count", int'(fifo_count), 0);
        check_eq("reset_err_pulses", int'({framing_err, overrun, parity_err}), 0);
        reset = 1'b0;
        repeat (5) tick();
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; bad_pulse = 0;

        // Single byte and exact out_valid latency.
        rise_cyc = -1;
        start = cyc;
        send_good(8'hA5);
        check_eq("a5_valid_rise_cycle", rise_cyc - start, LAT);
        check_eq("a5_out_data", int'(out_data), 8'hA5);
        check_eq("a5_fifo_count", int'(fifo_count), 1);
        check_eq("a5_no_err", fe_cnt + ov_cnt + pe_cnt, 0);
        drain(5);
        check_eq("a5_drained_count", int'(fifo_count), 0);

        // Fill past capacity; 17th byte dropped with one overrun pulse.
        ov0 = ov_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, ^(8'(i)));
        end
        check_eq("full_fifo_count", int'(fifo_count), DEPTH);
        check_eq("full_overrun_pulses", ov_cnt - ov0, 1);
        check_eq("full_head", int'(out_data), 0);
        drain(DEPTH + 4);
        check_eq("full_model_empty", exp_q.size(), 0);
        check_eq("full_drained_count", int'(fifo_count), 0);

        // Short low glitch is rejected silently.
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (30) tick();
        check_eq("glitch_fifo_count", int'(fifo_count), 0);
        check_eq("glitch_no_framing", fe_cnt - fe0, 0);
        send_good(8'h3C);
        check_eq("glitch_next_count", int'(fifo_count), 1);
        check_eq("glitch_next_data", int'(out_data), 8'h3C);
        drain(5);

        // Bad stop bit, line held low, then recovery.
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, ^(8'h55));
        rx = 1'b0;
        repeat (40) tick();
        rx = 1'b1;
        repeat (20) tick();
        check_eq("framing_pulses", fe_cnt - fe0, 1);
        check_eq("framing_no_push", int'(fifo_count), 0);
        send_good(8'h81);
        check_eq("framing_next_count", int'(fifo_count), 1);
        check_eq("framing_next_data", int'(out_data), 8'h81);
        check_eq("framing_no_extra", fe_cnt - fe0, 1);
        drain(5);

        // Reset during bit 4 of 0xFF with two bytes queued.
        send_good(8'hC3);
        send_good(8'h5A);
        check_eq("pre_reset_count", int'(fifo_count), 2);
        rx = 1'b0;
        repeat (DIV) tick();
        rx = 1'b1;
        repeat (4 * DIV + 5) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
        check_eq("midreset_count", int'(fifo_count), 0);
        check_eq("midreset_valid", int'(out_valid), 0);
        repeat (100) tick();
        check_eq("midreset_no_byte", int'(fifo_count), 0);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        check_eq("parity_ok_count", int'(fifo_count), 1);
        check_eq("parity_ok_data", int'(out_data), 8'h07);
        drain(5);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (5) tick();
        check_eq("parity_bad_pulse", pe_cnt - pe0, 1);
        check_eq("parity_bad_no_push", int'(fifo_count), 0);
`endif

        // Random bytes with random gaps and random consumer back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_good(rb);
            repeat ($urandom_range(0, 12)) tick();
        end
        rand_ready = 1'b0;
        drain(20);
        check_eq("rand_model_empty", exp_q.size(), 0);
        check_eq("rand_fifo_count", int'(fifo_count), 0);

        check_eq("total_framing", fe_cnt, 1);
        check_eq("total_overrun", ov_cnt, 1);
`ifdef UART_RX_PARITY_EN
        check_eq("total_parity", pe_cnt, 1);
`else
        check_eq("total_parity", pe_cnt, 0);
`endif
        check_eq("pulse_shape", bad_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
